// File: rtl/multi_issue_queue.sv
// ============================================================================
// Module      : multi_issue_queue
// Description : N-in / M-out in-order pipeline queue. A group of enqueue lanes
//               is accepted all-or-nothing, and up to OUT_LANES of the oldest
//               entries are presented each cycle. Optional empty-queue bypass
//               is enabled by defining MULTI_ISSUE_QUEUE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_issue_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int IN_LANES   = 2,
  parameter int OUT_LANES  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [IN_LANES-1:0]              in_valid,
  input  logic [IN_LANES*DATA_WIDTH-1:0]   in_data,
  output logic                             in_accept,
  output logic [OUT_LANES-1:0]             out_valid,
  output logic [OUT_LANES*DATA_WIDTH-1:0]  out_data,
  input  logic [OUT_LANES-1:0]             out_take,
  output logic [$clog2(DEPTH):0]           occupancy,
  output logic                             full,
  output logic                             empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [c_CNT_W-1:0]    r_count;

  logic [c_CNT_W-1:0]    w_push_cnt;
  logic [c_CNT_W-1:0]    w_push_acc;
  logic [c_CNT_W-1:0]    w_pop_cnt;
  logic [c_CNT_W-1:0]    w_skip;
  logic [c_PTR_W-1:0]    w_head_adv;
  logic [c_PTR_W-1:0]    w_tail_adv;
  logic                  w_accept;
  logic                  w_bypass;
  logic [OUT_LANES-1:0]  w_out_valid;
  logic [OUT_LANES-1:0]  w_taken;

`ifdef MULTI_ISSUE_QUEUE_BYPASS_EN
  assign w_bypass = (r_count == '0) && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_push_cnt = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      w_push_cnt = w_push_cnt + c_CNT_W'(in_valid[i]);
    end
  end

  // Space check uses only the registered count so out_take never reaches in_accept.
  assign w_accept   = !flush && ((c_CNT_W'(DEPTH) - r_count) >= w_push_cnt);
  assign w_push_acc = w_accept ? w_push_cnt : '0;

  generate
    for (genvar i = 0; i < OUT_LANES; i++) begin : g_out
      logic [c_PTR_W-1:0] w_rd_idx;
      assign w_rd_idx = r_head + c_PTR_W'(i);
      if (i < IN_LANES) begin : g_byp
        assign w_out_valid[i] = w_bypass ? in_valid[i] : (r_count > c_CNT_W'(i));
        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] =
          w_bypass ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : r_mem[w_rd_idx];
      end else begin : g_nobyp
        assign w_out_valid[i] = !w_bypass && (r_count > c_CNT_W'(i));
        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_rd_idx];
      end
    end
  endgenerate

  assign w_taken = out_take & w_out_valid;

  always_comb begin
    w_pop_cnt = '0;
    for (int i = 0; i < OUT_LANES; i++) begin
      w_pop_cnt = w_pop_cnt + c_CNT_W'(w_taken[i]);
    end
  end

  // Lanes consumed straight from the inputs skip storage and never move head.
  assign w_skip     = w_bypass ? w_pop_cnt : '0;
  assign w_head_adv = c_PTR_W'(w_pop_cnt - w_skip);
  assign w_tail_adv = c_PTR_W'(w_push_acc - w_skip);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < IN_LANES; i++) begin
        if (w_accept && in_valid[i] && (c_CNT_W'(i) >= w_skip)) begin
          r_mem[r_tail + c_PTR_W'(i) - c_PTR_W'(w_skip)] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_head_adv;
      r_tail  <= r_tail + w_tail_adv;
      r_count <= r_count + w_push_acc - w_pop_cnt;
    end
  end

  assign in_accept = w_accept;
  assign out_valid = w_out_valid;
  assign occupancy = r_count;
  assign full      = (r_count == c_CNT_W'(DEPTH));
  assign empty     = (r_count == '0);

  // Valid and take masks must be a run of ones starting at lane 0.
  a_in_valid_contig: assert property (@(posedge clk) disable iff (rst)
    ((in_valid & (in_valid + IN_LANES'(1))) == '0));
  a_out_take_contig: assert property (@(posedge clk) disable iff (rst)
    ((out_take & (out_take + OUT_LANES'(1))) == '0));

endmodule

`default_nettype wire
